// File: rtl/pb_pkg.sv
// Shared types for the push-button event decoder: event codes, FSM states and
// the sizing helper for the gesture counter.
package pb_pkg;

    typedef enum logic [1:0] {
        PB_EVT_SHORT  = 2'd0,
        PB_EVT_LONG   = 2'd1,
        PB_EVT_DOUBLE = 2'd2,
        PB_EVT_REPEAT = 2'd3
    } pb_evt_e;

    typedef enum logic [2:0] {
        PB_IDLE      = 3'd0,
        PB_PRESS     = 3'd1,
        PB_GAP       = 3'd2,
        PB_HOLD_LONG = 3'd3,
        PB_HOLD_WAIT = 3'd4
    } pb_state_e;

    // Largest of three cycle counts; the gesture counter must reach (max - 1).
    function automatic int pb_max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        return m;
    endfunction

endpackage

// File: rtl/pb_evt_slot.sv
// Single-entry valid/ready event register. A new event loads only when the slot
// is empty or being drained this cycle; otherwise it is discarded and flagged.
module pb_evt_slot
    import pb_pkg::*;
(
    input  logic    clk,
    input  logic    arst_n,
    input  logic    load,
    input  pb_evt_e load_code,
    input  logic    evt_ready,
    output logic    evt_valid,
    output pb_evt_e evt_code,
    output logic    evt_drop
);

    logic    valid_r;
    pb_evt_e code_r;
    logic    drop_r;
    logic    accept_s;

    // Slot can take a new event when empty or when the pending one leaves now.
    always_comb begin
        accept_s = 1'b0;
        if (!valid_r || evt_ready) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Pending event, its code and the one-cycle drop flag.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            valid_r <= 1'b0;
            code_r  <= PB_EVT_SHORT;
            drop_r  <= 1'b0;
        end else begin
            if (load && accept_s) begin
                valid_r <= 1'b1;
                code_r  <= load_code;
            end else if (evt_ready) begin
                valid_r <= 1'b0;
                code_r  <= code_r;
            end else begin
                valid_r <= valid_r;
                code_r  <= code_r;
            end
            drop_r <= load && !accept_s;
        end
    end

    assign evt_valid = valid_r;
    assign evt_code  = code_r;
    assign evt_drop  = drop_r;

endmodule

// File: rtl/pb_event_decoder.sv
// Classifies debounced button gestures into SHORT / LONG / DOUBLE events.
// Define PB_AUTO_REPEAT_EN to emit REPEAT periodically while a long press is held.
module pb_event_decoder
    import pb_pkg::*;
#(
    parameter int LONG_CNT   = 50_000_000,
    parameter int DCLICK_CNT = 15_000_000,
    parameter int REPEAT_CNT = 10_000_000
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       pb_stbl,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    input  logic       evt_ready,
    output logic       evt_drop,
    output logic       pressed
);

`ifdef PB_AUTO_REPEAT_EN
    localparam int CNT_MAX = pb_max3(LONG_CNT, DCLICK_CNT, REPEAT_CNT);
`else
    localparam int CNT_MAX = pb_max3(LONG_CNT, DCLICK_CNT, DCLICK_CNT);
`endif
    localparam int CNT_W = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CNT - 1);
`ifdef PB_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);
`endif

    if (LONG_CNT < 2 || DCLICK_CNT < 2 || REPEAT_CNT < 2) begin : g_bad_param
        $error("pb_event_decoder: LONG_CNT, DCLICK_CNT and REPEAT_CNT must be >= 2");
    end

    logic             pb_q_r;
    logic             rise_s;
    logic             fall_s;
    pb_state_e        state_r;
    pb_state_e        next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic             cnt_clr_s;
    logic             emit_s;
    pb_evt_e          emit_code_s;
    logic             rpt_s;
    pb_evt_e          slot_code_s;

    // Registered button level; also the externally visible 'pressed'.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pb_q_r <= 1'b0;
        end else begin
            pb_q_r <= pb_stbl;
        end
    end

    // Edges are taken against the registered level, so a button held through
    // reset release shows up as a fresh rise.
    always_comb begin
        rise_s = pb_stbl & ~pb_q_r;
        fall_s = ~pb_stbl & pb_q_r;
    end

    // Gesture state register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r <= PB_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a release always wins over a timer expiry.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            PB_IDLE: begin
                if (rise_s) begin
                    next_state_s = PB_PRESS;
                end else begin
                    next_state_s = PB_IDLE;
                end
            end
            PB_PRESS: begin
                if (fall_s) begin
                    next_state_s = PB_GAP;
                end else if (cnt_r == LONG_LAST) begin
                    next_state_s = PB_HOLD_LONG;
                end else begin
                    next_state_s = PB_PRESS;
                end
            end
            PB_GAP: begin
                if (rise_s) begin
                    next_state_s = PB_HOLD_WAIT;
                end else if (cnt_r == DCLICK_LAST) begin
                    next_state_s = PB_IDLE;
                end else begin
                    next_state_s = PB_GAP;
                end
            end
            PB_HOLD_LONG, PB_HOLD_WAIT: begin
                if (fall_s) begin
                    next_state_s = PB_IDLE;
                end else begin
                    next_state_s = state_r;
                end
            end
            default: begin
                next_state_s = PB_IDLE;
            end
        endcase
    end

    // Event emission decoded from the current state and the same conditions.
    always_comb begin
        emit_s      = 1'b0;
        emit_code_s = PB_EVT_SHORT;
        rpt_s       = 1'b0;
        case (state_r)
            PB_PRESS: begin
                if (!fall_s && cnt_r == LONG_LAST) begin
                    emit_s      = 1'b1;
                    emit_code_s = PB_EVT_LONG;
                end else begin
                    emit_s = 1'b0;
                end
            end
            PB_GAP: begin
                if (rise_s) begin
                    emit_s      = 1'b1;
                    emit_code_s = PB_EVT_DOUBLE;
                end else if (cnt_r == DCLICK_LAST) begin
                    emit_s      = 1'b1;
                    emit_code_s = PB_EVT_SHORT;
                end else begin
                    emit_s = 1'b0;
                end
            end
`ifdef PB_AUTO_REPEAT_EN
            PB_HOLD_LONG: begin
                if (!fall_s && cnt_r == REPEAT_LAST) begin
                    emit_s      = 1'b1;
                    emit_code_s = PB_EVT_REPEAT;
                    rpt_s       = 1'b1;
                end else begin
                    emit_s = 1'b0;
                end
            end
`endif
            default: begin
                emit_s = 1'b0;
            end
        endcase
    end

    // One counter serves every timed state: it restarts on each state change
    // and on each REPEAT so the period is measured from the previous event.
    always_comb begin
        cnt_clr_s = 1'b0;
        if ((next_state_s != state_r) || rpt_s) begin
            cnt_clr_s = 1'b1;
        end else begin
            cnt_clr_s = 1'b0;
        end
    end

    // Gesture timer.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_r <= '0;
        end else if (cnt_clr_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    pb_evt_slot u_slot (
        .clk       (clk),
        .arst_n    (arst_n),
        .load      (emit_s),
        .load_code (emit_code_s),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_code  (slot_code_s),
        .evt_drop  (evt_drop)
    );

    assign evt_code = slot_code_s;
    assign pressed  = pb_q_r;

endmodule

// File: tb/tb_pb_event_decoder.sv
// Self-checking bench for pb_event_decoder: random gesture streams compared
// against a duration-based event model, plus directed drop and reset scenarios.
module tb_pb_event_decoder;
    import pb_pkg::*;

    localparam int LONG = 20;
    localparam int DCLK = 8;
    localparam int RPT  = 5;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       pb_stbl;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       evt_ready;
    logic       evt_drop;
    logic       pressed;

    int checks   = 0;
    int failures = 0;

    typedef struct { int s; int p; int g; } press_t;
    typedef struct { int t; int code; }     ev_t;

    press_t pr_q[$];
    ev_t    exp_q[$];
    ev_t    obs_q[$];
    bit     lvl_q[$];

    always #5 clk = ~clk;

    pb_event_decoder #(
        .LONG_CNT   (LONG),
        .DCLICK_CNT (DCLK),
        .REPEAT_CNT (RPT)
    ) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .pb_stbl   (pb_stbl),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_ready (evt_ready),
        .evt_drop  (evt_drop),
        .pressed   (pressed)
    );

    task automatic tb_check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic lvl);
        pb_stbl = lvl;
        @(posedge clk);
        #1;
    endtask

    // Append one press of p cycles followed by g low cycles; ticks are numbered from 1.
    task automatic add_press(input int p, input int g);
        press_t pr;
        pr.s = lvl_q.size() + 1;
        pr.p = p;
        pr.g = g;
        pr_q.push_back(pr);
        for (int i = 0; i < p; i++) lvl_q.push_back(1'b1);
        for (int i = 0; i < g; i++) lvl_q.push_back(1'b0);
    endtask

    task automatic push_exp(input int t, input int code);
        ev_t e;
        e.t = t;
        e.code = code;
        exp_q.push_back(e);
    endtask

    // Gesture rules in terms of press and gap durations.
    task automatic build_expected();
        bit second;
        int f;
        second = 1'b0;
        for (int i = 0; i < pr_q.size(); i++) begin
            if (second) begin
                second = 1'b0;
            end else if (pr_q[i].p > LONG) begin
                push_exp(pr_q[i].s + LONG, 1);
`ifdef PB_AUTO_REPEAT_EN
                for (int n = 1; LONG + n * RPT < pr_q[i].p; n++)
                    push_exp(pr_q[i].s + LONG + n * RPT, 3);
`endif
            end else begin
                f = pr_q[i].s + pr_q[i].p;
                if (pr_q[i].g <= DCLK && i + 1 < pr_q.size()) begin
                    push_exp(f + pr_q[i].g, 2);
                    second = 1'b1;
                end else begin
                    push_exp(f + DCLK, 0);
                end
            end
        end
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        pb_stbl = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    initial begin
        int n_drop;
        int n_cmp;
        int n_valid;
        ev_t e;

        evt_ready = 1'b1;
        arst_n    = 1'b0;
        pb_stbl   = 1'b0;
        #1;
        tb_check("rst_valid", evt_valid, 0);
        tb_check("rst_code", evt_code, 0);
        tb_check("rst_drop", evt_drop, 0);
        tb_check("rst_pressed", pressed, 0);
        do_reset();

        // ---- random gesture stream with always-ready consumer ----
        for (int i = 0; i < 3; i++) lvl_q.push_back(1'b0);
        add_press(5, 20);
        add_press(32, 20);
        add_press(3, 4);
        add_press(3, 20);
        add_press(20, 20);
        add_press(21, 12);
        add_press(1, 8);
        add_press(2, 9);
        for (int i = 0; i < 16; i++) begin
            int p;
            int g;
            p = ($urandom_range(3, 0) == 0) ? $urandom_range(LONG + 1, LONG - 1)
                                            : $urandom_range(40, 1);
            g = $urandom_range(12, 1);
            add_press(p, g);
        end
        add_press($urandom_range(6, 1), 20);
        build_expected();

        n_drop = 0;
        for (int t = 1; t <= lvl_q.size(); t++) begin
            tick(lvl_q[t-1]);
            tb_check("pressed", pressed, lvl_q[t-1]);
            if (evt_valid) begin
                e.t = t;
                e.code = evt_code;
                obs_q.push_back(e);
            end
            if (evt_drop) n_drop++;
        end
        tb_check("evt_count", obs_q.size(), exp_q.size());
        n_cmp = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n_cmp; i++) begin
            tb_check("evt_time", obs_q[i].t, exp_q[i].t);
            tb_check("evt_code", obs_q[i].code, exp_q[i].code);
        end
        tb_check("no_drop_when_ready", n_drop, 0);

        // ---- back-pressure: SHORT held, LONG dropped ----
        do_reset();
        evt_ready = 1'b0;
        tick(1'b0);
        tick(1'b0);
        for (int i = 0; i < 5; i++) tick(1'b1);
        for (int i = 0; i < 8; i++) tick(1'b0);
        tb_check("short_not_yet", evt_valid, 0);
        tick(1'b0);
        tb_check("short_valid", evt_valid, 1);
        tb_check("short_code", evt_code, 0);
        for (int i = 0; i < 3; i++) tick(1'b0);
        for (int i = 0; i < 20; i++) tick(1'b1);
        tb_check("drop_before_long", evt_drop, 0);
        tick(1'b1);
        tb_check("drop_at_long", evt_drop, 1);
        tb_check("held_valid", evt_valid, 1);
        tb_check("held_code", evt_code, 0);
        tick(1'b1);
        tb_check("drop_one_cycle", evt_drop, 0);
        tb_check("held_code2", evt_code, 0);
        tick(1'b0);
        evt_ready = 1'b1;
        tick(1'b0);
        tb_check("drained", evt_valid, 0);

        // ---- asynchronous reset mid-press with an event pending ----
        evt_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b0);
        for (int i = 0; i < 5; i++) tick(1'b1);
        for (int i = 0; i < 9; i++) tick(1'b0);
        tb_check("pend_valid", evt_valid, 1);
        for (int i = 0; i < 11; i++) tick(1'b1);
        #2;
        arst_n = 1'b0;
        #1;
        tb_check("arst_valid", evt_valid, 0);
        tb_check("arst_code", evt_code, 0);
        tb_check("arst_drop", evt_drop, 0);
        tb_check("arst_pressed", pressed, 0);
        pb_stbl = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        evt_ready = 1'b1;
        n_valid = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1'b0);
            if (evt_valid || evt_drop) n_valid++;
        end
        tb_check("post_rst_quiet", n_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pb_event_decoder.md
# pb_event_decoder

Consumer-side companion of the push-button debouncer. Takes the debounced, clock-synchronous button level and classifies gestures into discrete events: short press, long press, double click, and optionally auto-repeat while held. Events go to downstream control logic such as menu or mode FSMs through a single-entry valid/ready output register. Sits directly after the debouncer in every button path.

## Interface
- `LONG_CNT`, 50_000_000: cycles the button must stay held to raise LONG (1 s @ 50 MHz); ≥2.
- `DCLICK_CNT`, 15_000_000: maximum release-gap cycles for a second press to count as DOUBLE; ≥2.
- `REPEAT_CNT`, 10_000_000: REPEAT period after LONG; ≥2; used only with the macro.
- `clk` in 1: clock.
- `arst_n` in 1: reset, asynchronous, active-low.
- `pb_stbl` in 1: debounced button level, synchronous to `clk`, 1 = pressed.
- `evt_valid` out 1: event pending.
- `evt_code` out 2: `pb_evt_e`. SHORT=0, LONG=1, DOUBLE=2, REPEAT=3.
- `evt_ready` in 1: consumer accepts the pending event.
- `evt_drop` out 1: 1-cycle pulse when an event is lost because the output register is full.
- `pressed` out 1: registered copy of `pb_stbl` (`pb_q`).

## Operation
- Edge detect: `pb_q <= pb_stbl`. rise = `pb_stbl & ~pb_q`; fall = `~pb_stbl & pb_q`.
- Single counter `cnt`, width `$clog2(max(LONG_CNT,DCLICK_CNT,REPEAT_CNT))`. Cleared on every state change, otherwise increments each cycle.
- FSM `pb_state_e`:
  - IDLE: rise → PRESS.
  - PRESS: fall → GAP (fall has priority). Else if `cnt==LONG_CNT-1` → emit LONG → HOLD_LONG.
  - GAP: rise → emit DOUBLE → HOLD_WAIT. Else if `cnt==DCLICK_CNT-1` → emit SHORT → IDLE.
  - HOLD_LONG: fall → IDLE. With the macro, `cnt==REPEAT_CNT-1` → emit REPEAT and clear `cnt`.
  - HOLD_WAIT: fall → IDLE. No LONG or REPEAT after DOUBLE.
- Emit rules:
  - The event loads `evt_code` and sets `evt_valid` if `!evt_valid || evt_ready`.
  - Otherwise it is discarded, `evt_drop` pulses, and the pending event stays unchanged.
- Handshake: `evt_valid && evt_ready` at an edge clears `evt_valid` unless a new event loads in the same cycle. In that case `evt_valid` stays 1 with the new code.
- `evt_code` is stable while `evt_valid=1` and is not accepted.
- A button held through reset deassertion is seen as a rise on the first edge, i.e. a new press.

## Timing
- Reset values: IDLE, `cnt=0`, `pb_q=0`, `evt_valid=0`, `evt_code=0`, `evt_drop=0`, `pressed=0`.
- Reset mid-operation discards all gesture state and any pending event.
- Edge k is the edge where the rise is sampled. LONG: `evt_valid` is high after edge k+LONG_CNT.
- SHORT: `evt_valid` is high DCLICK_CNT edges after the edge that samples the fall.
- DOUBLE: `evt_valid` is high after the edge that samples the second rise.
- REPEAT: every REPEAT_CNT edges after LONG while held.
- No combinational path from `pb_stbl` or `evt_ready` to any output.

## Configuration
- `PB_AUTO_REPEAT_EN` defined: HOLD_LONG emits REPEAT every REPEAT_CNT cycles.
- Undefined: HOLD_LONG only waits for release; REPEAT is never produced and `REPEAT_CNT` is ignored for counter sizing.

## Structure
- Package `pb_pkg` holds:
  - `pb_evt_e` (2-bit event codes)
  - `pb_state_e` (IDLE, PRESS, GAP, HOLD_LONG, HOLD_WAIT)
  - function `pb_max3` used for counter sizing
- Sub-module `pb_evt_slot` is the single-entry valid/ready output register with drop detection. The FSM and counter live in the top level.

## Test plan
Bench parameters: LONG_CNT=20, DCLICK_CNT=8, REPEAT_CNT=5.

- Press 5 cycles, release → one SHORT (code 0), valid 8 edges after the fall edge. `pressed` tracks with 1-cycle lag.
- Hold 32 cycles → LONG (1) after 20 edges.
  - Macro on: REPEAT (3) after edges 25 and 30, none after release.
  - Macro off: only LONG.
- Press 3, release 4, press 3 → DOUBLE (2) one edge after the second rise. No SHORT or LONG follows.
- `evt_ready=0`, produce SHORT then LONG → SHORT stays pending, one `evt_drop` pulse at the LONG emit. Raising `evt_ready` clears `evt_valid` next edge.
- Release sampled exactly when `cnt==19` in PRESS → no LONG. SHORT 8 edges later.
- Assert `arst_n=0` at `cnt==10` in PRESS with an event pending → all outputs 0 immediately. Release reset with the button low → no event.
